// File: rtl/phase_manager.sv
// Phase-shedding controller: adds/sheds buck phases on PWM period boundaries
// with hysteresis and dwell. Optional shoot-through guard: define SHOOT_GUARD_EN.
module phase_manager #(
   parameter int NPHASES    = 4,
   parameter int DWELL      = 8,
   parameter int TH_UP      = 600,
   parameter int TH_DN      = 300,
   parameter int MIN_PHASES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_pwm,
   input  logic               force_all,
   input  logic               period_tick,
   input  logic [9:0]         load_metric,
   input  logic [NPHASES-1:0] pwm_high_in,
   input  logic [NPHASES-1:0] pwm_low_in,
   output logic [NPHASES-1:0] gate_high,
   output logic [NPHASES-1:0] gate_low,
   output logic [NPHASES-1:0] phase_mask,
   output logic [2:0]         n_active,
   output logic               running,
   output logic               fault
);

   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [9:0]    TH_UP_W    = 10'(TH_UP);
   localparam logic [9:0]    TH_DN_W    = 10'(TH_DN);
   localparam logic [2:0]    NP_W       = 3'(NPHASES);
   localparam logic [2:0]    MIN_W      = 3'(MIN_PHASES);

   if (TH_DN >= TH_UP) begin : g_bad_thresholds
      $error("phase_manager: TH_DN must be below TH_UP");
   end
   if (NPHASES < 2 || NPHASES > 4 || MIN_PHASES < 1 || MIN_PHASES > NPHASES) begin : g_bad_phases
      $error("phase_manager: phase count parameters out of range");
   end

   typedef enum logic {OFF, RUN} state_t;

   state_t               state, state_nx;
   logic [2:0]           n_nx;
   logic [CW-1:0]        up_cnt, up_nx, dn_cnt, dn_nx;
   logic [NPHASES-1:0]   mask_nx, gate_high_nx, gate_low_nx;
   logic                 fault_nx;

   // Thermometer mask: phase 0 is always the first phase brought up.
   function automatic logic [NPHASES-1:0] mask_of(input logic [2:0] n);
      logic [NPHASES-1:0] m;
      for (int i = 0; i < NPHASES; i++) m[i] = (i < int'(n));
      return m;
   endfunction

   always_comb begin
      state_nx = state;
      n_nx     = n_active;
      up_nx    = up_cnt;
      dn_nx    = dn_cnt;
      case (state)
         OFF: begin
            n_nx  = 3'd0;
            up_nx = '0;
            dn_nx = '0;
            if (period_tick && en_pwm) begin
               state_nx = RUN;
               n_nx     = force_all ? NP_W : MIN_W;
            end
         end
         RUN: begin
            if (!en_pwm) begin
               state_nx = OFF;
               n_nx     = 3'd0;
               up_nx    = '0;
               dn_nx    = '0;
            end else if (period_tick) begin
               if (force_all) begin
                  n_nx  = NP_W;
                  up_nx = '0;
                  dn_nx = '0;
               end else if (load_metric >= TH_UP_W && n_active < NP_W) begin
                  dn_nx = '0;
                  if (up_cnt >= DWELL_LAST) begin
                     n_nx  = n_active + 3'd1;
                     up_nx = '0;
                  end else begin
                     up_nx = up_cnt + CNT_ONE;
                  end
               end else if (load_metric <= TH_DN_W && n_active > MIN_W) begin
                  up_nx = '0;
                  if (dn_cnt >= DWELL_LAST) begin
                     n_nx  = n_active - 3'd1;
                     dn_nx = '0;
                  end else begin
                     dn_nx = dn_cnt + CNT_ONE;
                  end
               end else begin
                  up_nx = '0;
                  dn_nx = '0;
               end
            end
         end
         default: state_nx = OFF;
      endcase
      mask_nx = mask_of(n_nx);
   end

   // Gates follow the registered mask; dropping en_pwm blanks them on the very next edge.
`ifdef SHOOT_GUARD_EN
   logic [NPHASES-1:0] overlap;
   always_comb begin
      overlap      = pwm_high_in & pwm_low_in & phase_mask;
      gate_high_nx = pwm_high_in & phase_mask & ~overlap & {NPHASES{en_pwm}};
      gate_low_nx  = pwm_low_in  & phase_mask & ~overlap & {NPHASES{en_pwm}};
      fault_nx     = fault | (|overlap);
   end
`else
   always_comb begin
      gate_high_nx = pwm_high_in & phase_mask & {NPHASES{en_pwm}};
      gate_low_nx  = pwm_low_in  & phase_mask & {NPHASES{en_pwm}};
      fault_nx     = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= OFF;
         n_active   <= 3'd0;
         up_cnt     <= '0;
         dn_cnt     <= '0;
         phase_mask <= '0;
         gate_high  <= '0;
         gate_low   <= '0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nx;
         n_active   <= n_nx;
         up_cnt     <= up_nx;
         dn_cnt     <= dn_nx;
         phase_mask <= mask_nx;
         gate_high  <= gate_high_nx;
         gate_low   <= gate_low_nx;
         fault      <= fault_nx;
      end
   end

   assign running = (state == RUN);

endmodule

// File: tb/tb_phase_manager.sv
// Randomized self-checking bench for phase_manager against a rule-level reference model.
module tb_phase_manager;

   localparam int NP  = 4;
   localparam int GAP = 8;

   logic          clk = 1'b0;
   logic          rst, en_pwm, force_all, period_tick;
   logic [9:0]    load_metric;
   logic [NP-1:0] pwm_high_in, pwm_low_in;
   logic [NP-1:0] gate_high, gate_low, phase_mask;
   logic [2:0]    n_active;
   logic          running, fault;

   int checks = 0;
   int failures = 0;
   bit auto_pwm = 1'b1;

   // Reference model state
   int m_run, m_n, m_up, m_dn, m_mask, m_gh, m_gl, m_fault;

   always #5 clk = ~clk;

   phase_manager dut (
      .clk(clk), .rst(rst), .en_pwm(en_pwm), .force_all(force_all),
      .period_tick(period_tick), .load_metric(load_metric),
      .pwm_high_in(pwm_high_in), .pwm_low_in(pwm_low_in),
      .gate_high(gate_high), .gate_low(gate_low), .phase_mask(phase_mask),
      .n_active(n_active), .running(running), .fault(fault)
   );

   // One clock edge applied to the rule-level model, using inputs held across the edge.
   task automatic model_update();
      int h, l, ov;
      if (rst) begin
         m_run = 0; m_n = 0; m_up = 0; m_dn = 0; m_mask = 0;
         m_gh = 0; m_gl = 0; m_fault = 0;
         return;
      end
      h  = int'(pwm_high_in);
      l  = int'(pwm_low_in);
      ov = h & l & m_mask;
`ifdef SHOOT_GUARD_EN
      m_gh = h & m_mask & ~ov;
      m_gl = l & m_mask & ~ov;
      if (ov != 0) m_fault = 1;
`else
      m_gh = h & m_mask;
      m_gl = l & m_mask;
`endif
      if (!en_pwm) begin m_gh = 0; m_gl = 0; end
      if (m_run == 0) begin
         if (period_tick && en_pwm) begin
            m_run = 1;
            m_n   = force_all ? NP : 1;
         end
      end else if (!en_pwm) begin
         m_run = 0; m_n = 0; m_up = 0; m_dn = 0;
      end else if (period_tick) begin
         if (force_all) begin
            m_n = NP; m_up = 0; m_dn = 0;
         end else if (load_metric >= 600 && m_n < NP) begin
            m_dn = 0; m_up++;
            if (m_up == 8) begin m_n++; m_up = 0; end
         end else if (load_metric <= 300 && m_n > 1) begin
            m_up = 0; m_dn++;
            if (m_dn == 8) begin m_n--; m_dn = 0; end
         end else begin
            m_up = 0; m_dn = 0;
         end
      end
      m_mask = (1 << m_n) - 1;
   endtask

   task automatic step();
      if (auto_pwm) begin
         pwm_high_in = 4'($urandom);
         pwm_low_in  = ~pwm_high_in;
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic periods(input int k);
      for (int p = 0; p < k; p++) begin
         period_tick = 1'b1;
         step();
         period_tick = 1'b0;
         for (int c = 1; c < GAP; c++) step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en_pwm = 1'b1; force_all = 1'b0; period_tick = 1'b1;
      load_metric = 10'd100;
      step(); step(); step();
      checks++;
      if ({running, n_active, phase_mask, gate_high, gate_low, fault} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: run=%0b n=%0d mask=%b gh=%b gl=%b fault=%0b required all 0",
                  running, n_active, phase_mask, gate_high, gate_low, fault);
      end
      period_tick = 1'b0;
      rst = 1'b0;
      step();
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: running=%0b required 0", running);
      end
   endtask

   task automatic test_startup();
      load_metric = 10'd100;
      periods(1);
      checks++;
      if (running !== 1'b1 || n_active !== 3'd1 || phase_mask !== 4'b0001) begin
         failures++;
         $display("FAIL startup: run=%0b n=%0d mask=%b required 1 1 0001", running, n_active, phase_mask);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (gate_high !== m_gh[NP-1:0] || gate_high[3:1] !== 3'b000) begin
            failures++;
            $display("FAIL startup_gate: gate_high=%b required %b", gate_high, m_gh[NP-1:0]);
         end
      end
   endtask

   task automatic test_hysteresis_break();
      load_metric = 10'd700; periods(5);
      load_metric = 10'd450; periods(1);
      load_metric = 10'd700; periods(7);
      checks++;
      if (n_active !== 3'd1) begin
         failures++;
         $display("FAIL hyst_break_hold: n=%0d required 1", n_active);
      end
      periods(1);
      checks++;
      if (n_active !== 3'd2) begin
         failures++;
         $display("FAIL hyst_break_add: n=%0d required 2", n_active);
      end
   endtask

   task automatic test_ramp_up();
      load_metric = 10'd700;
      periods(8);
      checks++;
      if (n_active !== 3'd3 || phase_mask !== 4'b0111) begin
         failures++;
         $display("FAIL ramp_3: n=%0d mask=%b required 3 0111", n_active, phase_mask);
      end
      periods(8);
      checks++;
      if (n_active !== 3'd4) begin
         failures++;
         $display("FAIL ramp_4: n=%0d required 4", n_active);
      end
      periods(10);
      checks++;
      if (n_active !== 3'd4 || phase_mask !== 4'b1111) begin
         failures++;
         $display("FAIL ramp_sat: n=%0d mask=%b required 4 1111", n_active, phase_mask);
      end
   endtask

   task automatic test_shed();
      load_metric = 10'd200;
      periods(7);
      checks++;
      if (n_active !== 3'd4) begin
         failures++;
         $display("FAIL shed_dwell: n=%0d required 4", n_active);
      end
      periods(1);
      checks++;
      if (n_active !== 3'd3) begin
         failures++;
         $display("FAIL shed_3: n=%0d required 3", n_active);
      end
      periods(16);
      checks++;
      if (n_active !== 3'd1 || phase_mask !== 4'b0001) begin
         failures++;
         $display("FAIL shed_1: n=%0d mask=%b required 1 0001", n_active, phase_mask);
      end
      periods(12);
      checks++;
      if (n_active !== 3'd1) begin
         failures++;
         $display("FAIL shed_min: n=%0d required 1", n_active);
      end
   endtask

   task automatic test_force();
      load_metric = 10'd700; periods(3);
      force_all = 1'b1; periods(1);
      checks++;
      if (n_active !== 3'd4 || phase_mask !== 4'b1111) begin
         failures++;
         $display("FAIL force_on: n=%0d mask=%b required 4 1111", n_active, phase_mask);
      end
      force_all = 1'b0; load_metric = 10'd200;
      periods(8);
      checks++;
      if (n_active !== 3'd3) begin
         failures++;
         $display("FAIL force_release_shed: n=%0d required 3", n_active);
      end
   endtask

   task automatic test_disable();
      period_tick = 1'b0;
      step(); step(); step();
      en_pwm = 1'b0;
      step();
      checks++;
      if (running !== 1'b0 || phase_mask !== 4'b0000 || gate_high !== 4'b0 || gate_low !== 4'b0) begin
         failures++;
         $display("FAIL disable: run=%0b mask=%b gh=%b gl=%b required 0 0000 0000 0000",
                  running, phase_mask, gate_high, gate_low);
      end
      step(); step();
      en_pwm = 1'b1; load_metric = 10'd100;
      periods(1);
      checks++;
      if (running !== 1'b1 || n_active !== 3'd1) begin
         failures++;
         $display("FAIL reenable: run=%0b n=%0d required 1 1", running, n_active);
      end
   endtask

   task automatic test_random();
      int loads[9] = '{0, 200, 300, 301, 450, 599, 600, 700, 1023};
      for (int c = 0; c < 1500; c++) begin
         period_tick = (c % 5 == 0);
         if (period_tick) load_metric = 10'(loads[$urandom_range(0, 8)]);
         force_all = ($urandom_range(0, 39) == 0);
         en_pwm    = ($urandom_range(0, 149) != 0);
         rst       = ($urandom_range(0, 499) == 0);
         step();
         checks++;
         if (running !== m_run[0] || n_active !== m_n[2:0] || phase_mask !== m_mask[NP-1:0] ||
             gate_high !== m_gh[NP-1:0] || gate_low !== m_gl[NP-1:0] || fault !== m_fault[0]) begin
            failures++;
            $display("FAIL random_cyc%0d: run=%0b n=%0d mask=%b gh=%b gl=%b f=%0b required %0d %0d %b %b %b %0d",
                     c, running, n_active, phase_mask, gate_high, gate_low, fault,
                     m_run, m_n, m_mask[NP-1:0], m_gh[NP-1:0], m_gl[NP-1:0], m_fault);
         end
      end
      rst = 1'b0; force_all = 1'b0; en_pwm = 1'b1;
   endtask

   task automatic test_shoot_through();
      force_all = 1'b1; periods(1);
      force_all = 1'b0; load_metric = 10'd450;
      auto_pwm = 1'b0;
      pwm_high_in = 4'b0001; pwm_low_in = 4'b0001;
      step();
      checks++;
`ifdef SHOOT_GUARD_EN
      if (gate_high[0] !== 1'b0 || gate_low[0] !== 1'b0 || fault !== 1'b1) begin
         failures++;
         $display("FAIL shoot_guard: gh0=%0b gl0=%0b fault=%0b required 0 0 1", gate_high[0], gate_low[0], fault);
      end
`else
      if (gate_high[0] !== 1'b1 || gate_low[0] !== 1'b1 || fault !== 1'b0) begin
         failures++;
         $display("FAIL shoot_pass: gh0=%0b gl0=%0b fault=%0b required 1 1 0", gate_high[0], gate_low[0], fault);
      end
`endif
      pwm_high_in = 4'b0001; pwm_low_in = 4'b0000;
      step(); step();
      checks++;
      if (fault !== m_fault[0] || gate_high !== m_gh[NP-1:0]) begin
         failures++;
         $display("FAIL shoot_persist: fault=%0b gh=%b required %0d %b", fault, gate_high, m_fault, m_gh[NP-1:0]);
      end
      rst = 1'b1; step(); rst = 1'b0;
      checks++;
      if (fault !== 1'b0) begin
         failures++;
         $display("FAIL shoot_clear: fault=%0b required 0", fault);
      end
      auto_pwm = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en_pwm = 1'b0; force_all = 1'b0; period_tick = 1'b0;
      load_metric = 10'd0; pwm_high_in = '0; pwm_low_in = '0;
      test_reset();
      test_startup();
      test_hysteresis_break();
      test_ramp_up();
      test_shed();
      test_force();
      test_disable();
      test_random();
      test_shoot_through();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
